// File: rtl/i_cache_set_assoc_if.sv
// i_cache_set_assoc_if: fetch, fill and statistics signals between core/memory and the instruction cache
interface i_cache_set_assoc_if #(
    parameter int CL_WORDS = 4,
    parameter int CNT_W    = 32
);
    logic [31:0]             pc;
    logic                    pc_valid;
    logic                    flush;
    logic [31:0]             instr;
    logic                    instr_valid;
    logic                    stall_pc;
    logic                    mem_req_valid;
    logic [31:0]             mem_req_addr;
    logic                    mem_req_ready;
    logic                    mem_rsp_valid;
    logic [CL_WORDS*32-1:0]  mem_rsp_data;
    logic [CNT_W-1:0]        hit_cnt;
    logic [CNT_W-1:0]        miss_cnt;
    modport master (
        output pc, pc_valid, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  instr, instr_valid, stall_pc, mem_req_valid, mem_req_addr, hit_cnt, miss_cnt
    );
    modport slave (
        input  pc, pc_valid, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output instr, instr_valid, stall_pc, mem_req_valid, mem_req_addr, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/i_cache_set_assoc.sv
// i_cache_set_assoc: set-associative instruction cache with tree-PLRU replacement and fence.i flush
module i_cache_set_assoc #(
    parameter int WAYS     = 4,
    parameter int SETS     = 16,
    parameter int CL_WORDS = 4,
    parameter int CNT_W    = 32
) (
    input logic clk,
    input logic rst,
    i_cache_set_assoc_if.slave bus
);
    localparam int OFF_W = $clog2(CL_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, FLUSH} state_t;

    state_t state, state_n;
    logic [CL_WORDS-1:0][31:0] data_q [SETS][WAYS];
    logic [TAG_W-1:0]          tag_q  [SETS][WAYS];
    logic [WAYS-1:0]           valid_q [SETS];
    logic [WAYS-2:0]           plru_q  [SETS];
    logic [CL_WORDS-1:0][31:0] fill_q;
    logic [WAY_W-1:0]          victim_q, victim, hit_way;
    logic [IDX_W-1:0]          fcnt;
    logic                      flush_pend, hit, lookup_hit, miss;
    logic [OFF_W-1:0]          off;
    logic [IDX_W-1:0]          idx, f_idx;
    logic [TAG_W-1:0]          tag, f_tag;

    assign off   = bus.pc[OFF_W+1:2];
    assign idx   = bus.pc[OFF_W+IDX_W+1:OFF_W+2];
    assign tag   = bus.pc[31:OFF_W+IDX_W+2];
    assign f_idx = bus.mem_req_addr[OFF_W+IDX_W+1:OFF_W+2];
    assign f_tag = bus.mem_req_addr[31:OFF_W+IDX_W+2];

    // Tree walk from the root: a node bit of 0 sends the victim search left, 1 right.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] t);
        int   n;
        logic b;
        n = 1;
        for (int l = 0; l < WAY_W; l++) begin
            b = 1'b0;
            for (int k = 0; k < WAYS - 1; k++) if (k + 1 == n) b = t[k];
            n = 2 * n + (b ? 1 : 0);
        end
        return WAY_W'(n - WAYS);
    endfunction

    // Every node on the path to the accessed way is turned to point at the other subtree.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t, input logic [WAY_W-1:0] w);
        logic [WAYS-2:0] r;
        int              n;
        logic            d;
        r = t;
        n = 1;
        for (int l = 0; l < WAY_W; l++) begin
            d = w[WAY_W-1-l];
            for (int k = 0; k < WAYS - 1; k++) if (k + 1 == n) r[k] = ~d;
            n = 2 * n + (d ? 1 : 0);
        end
        return r;
    endfunction

    // Tag compare across the indexed set and victim choice (lowest invalid way, else PLRU).
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        victim  = plru_victim(plru_q[idx]);
        for (int w = 0; w < WAYS; w++)
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_q[idx][w]) victim = WAY_W'(w);
    end

    assign lookup_hit = state == IDLE && !bus.flush && bus.pc_valid && hit;
    assign miss       = state == IDLE && !bus.flush && bus.pc_valid && !hit;

    // Next-state logic; the core is held in every state but IDLE, and in IDLE on a miss or flush.
    always_comb begin
        state_n      = state;
        bus.stall_pc = 1'b1;
        case (state)
            IDLE: begin
                bus.stall_pc = bus.flush || miss;
                state_n      = bus.flush ? FLUSH : miss ? REQ : IDLE;
            end
            REQ:     state_n = bus.mem_req_ready ? WAIT : REQ;
            WAIT:    state_n = bus.mem_rsp_valid ? FILL : WAIT;
            FILL:    state_n = (flush_pend || bus.flush) ? FLUSH : IDLE;
            FLUSH:   state_n = fcnt == IDX_W'(SETS - 1) ? IDLE : FLUSH;
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Control, valid/PLRU bookkeeping, outputs and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.instr         <= '0;
            bus.instr_valid   <= 1'b0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_addr  <= '0;
            bus.hit_cnt       <= '0;
            bus.miss_cnt      <= '0;
            flush_pend        <= 1'b0;
            fcnt              <= '0;
            victim_q          <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            bus.instr_valid   <= lookup_hit;
            bus.mem_req_valid <= state_n == REQ;
            flush_pend        <= state_n != FLUSH && (flush_pend || (bus.flush && state != IDLE && state != FLUSH));
            fcnt              <= state == FLUSH ? fcnt + IDX_W'(1) : '0;
            if (lookup_hit) begin
                bus.instr   <= data_q[idx][hit_way][off];
                plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
                bus.hit_cnt <= bus.hit_cnt + CNT_W'(bus.hit_cnt != '1);
            end
            if (miss) begin
                bus.mem_req_addr <= {bus.pc[31:OFF_W+2], {(OFF_W + 2){1'b0}}};
                victim_q         <= victim;
                bus.miss_cnt     <= bus.miss_cnt + CNT_W'(bus.miss_cnt != '1);
            end
            if (state == FILL) begin
                valid_q[f_idx][victim_q] <= 1'b1;
                plru_q[f_idx]            <= plru_touch(plru_q[f_idx], victim_q);
            end
            if (state == FLUSH) begin
                valid_q[fcnt] <= '0;
                plru_q[fcnt]  <= '0;
            end
        end
    end

    // Line and tag storage; deliberately left unreset since valid bits guard it.
    always_ff @(posedge clk) begin
        if (state == WAIT && bus.mem_rsp_valid) fill_q <= bus.mem_rsp_data;
        if (state == FILL) begin
            data_q[f_idx][victim_q] <= fill_q;
            tag_q[f_idx][victim_q]  <= f_tag;
        end
    end
endmodule

// File: tb/tb_i_cache_set_assoc.sv
// tb_i_cache_set_assoc: table-driven fetch vectors with an instruction scoreboard plus hand-written corner sequences
module tb_i_cache_set_assoc;
    localparam int WAYS     = 4;
    localparam int SETS     = 16;
    localparam int CL_WORDS = 4;
    localparam int CNT_W    = 4;
    localparam int CMAX     = (1 << CNT_W) - 1;
    localparam int NV       = 17;

    typedef struct {
        logic [31:0] pc;
        logic        miss;
        int          dly;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    vec_t tv [NV];
    logic [31:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int n_hit  = 0;
    int n_miss = 0;
    int cnt;

    always #5 clk = ~clk;

    i_cache_set_assoc_if #(.CL_WORDS(CL_WORDS), .CNT_W(CNT_W)) bus ();

    i_cache_set_assoc #(.WAYS(WAYS), .SETS(SETS), .CL_WORDS(CL_WORDS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory content: every line carries distinct words; line 0x100 holds 0xAAAA0000..3.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] ln;
        ln = {a[31:4], 4'b0};
        return 32'hAAAA0000 + ((ln - 32'h100) << 4) + {30'b0, a[3:2]};
    endfunction

    function automatic logic [CL_WORDS*32-1:0] mem_line(input logic [31:0] ln);
        logic [CL_WORDS*32-1:0] r;
        for (int i = 0; i < CL_WORDS; i++) r[i*32 +: 32] = mem_word(ln + 32'(4 * i));
        return r;
    endfunction

    function automatic int sat(input int n);
        return n > CMAX ? CMAX : n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Scoreboard: each delivered instruction is matched against the oldest expectation.
    always @(negedge clk) begin
        if (bus.instr_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL instr_spurious got=%h want=none", bus.instr);
            end else chk("instr", bus.instr, exp_q.pop_front());
        end
    end

    task automatic wait_unstall(input string name);
        int t = 0;
        #1;
        while (bus.stall_pc && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk(name, bus.stall_pc, 0);
    endtask

    task automatic serve_req(input logic [31:0] ln, input int dly);
        int t = 0;
        while (!bus.mem_req_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("req_valid", bus.mem_req_valid, 1);
        chk("req_addr", bus.mem_req_addr, ln);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("bp_valid", bus.mem_req_valid, 1);
            chk("bp_addr", bus.mem_req_addr, ln);
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        chk("req_once", bus.mem_req_valid, 0);
    endtask

    task automatic send_rsp(input logic [31:0] ln);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = mem_line(ln);
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
    endtask

    task automatic serve(input logic [31:0] ln, input int dly);
        serve_req(ln, dly);
        @(negedge clk);
        send_rsp(ln);
    endtask

    task automatic fetch(input logic [31:0] a, input logic exp_miss, input int dly);
        @(negedge clk);
        bus.pc       = a;
        bus.pc_valid = 1'b1;
        #1;
        chk($sformatf("stall@%h", a), bus.stall_pc, exp_miss);
        if (exp_miss) n_miss++;
        if (bus.stall_pc) begin
            serve({a[31:4], 4'b0}, dly);
            wait_unstall("refill_hit");
        end
        n_hit++;
        exp_q.push_back(mem_word(a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pc            = '0;
        bus.pc_valid      = 1'b0;
        bus.flush         = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        tv[0]  = '{32'h1010, 1'b1, 0};
        tv[1]  = '{32'h1014, 1'b0, 0};
        tv[2]  = '{32'h2010, 1'b1, 7};
        tv[3]  = '{32'h1018, 1'b0, 0};
        tv[4]  = '{32'h3010, 1'b1, 0};
        tv[5]  = '{32'h101C, 1'b0, 0};
        tv[6]  = '{32'h4010, 1'b1, 2};
        tv[7]  = '{32'h1010, 1'b0, 0};
        tv[8]  = '{32'h5010, 1'b1, 0};
        tv[9]  = '{32'h1014, 1'b0, 0};
        tv[10] = '{32'h2014, 1'b0, 0};
        tv[11] = '{32'h4014, 1'b0, 0};
        tv[12] = '{32'h5014, 1'b0, 0};
        tv[13] = '{32'h3010, 1'b1, 0};
        tv[14] = '{32'h0020, 1'b1, 0};
        tv[15] = '{32'h0024, 1'b0, 0};
        tv[16] = '{32'h010C, 1'b0, 0};
        repeat (2) @(negedge clk);
        chk("rst_instr", bus.instr, 0);
        chk("rst_instr_valid", bus.instr_valid, 0);
        chk("rst_req_valid", bus.mem_req_valid, 0);
        chk("rst_req_addr", bus.mem_req_addr, 0);
        chk("rst_hit_cnt", bus.hit_cnt, 0);
        chk("rst_miss_cnt", bus.miss_cnt, 0);
        chk("rst_stall", bus.stall_pc, 0);
        rst = 1'b0;
        // Cold miss on 0x100, then a hit on the neighbouring word.
        @(negedge clk);
        bus.pc       = 32'h100;
        bus.pc_valid = 1'b1;
        #1;
        chk("cold_stall", bus.stall_pc, 1);
        n_miss++;
        serve(32'h100, 0);
        bus.pc_valid = 1'b0;
        wait_unstall("cold_fill_done");
        fetch(32'h104, 1'b0, 0);
        @(negedge clk);
        bus.pc_valid = 1'b0;
        #1;
        chk("cold_hit_cnt", bus.hit_cnt, 1);
        chk("cold_miss_cnt", bus.miss_cnt, 1);
        // Set conflict, backpressure and mixed sets from the vector table.
        for (int i = 0; i < NV; i++) fetch(tv[i].pc, tv[i].miss, tv[i].dly);
        for (int i = 0; i < 20; i++) fetch(32'h100 + 32'(4 * (i % 4)), 1'b0, 0);
        @(negedge clk);
        bus.pc_valid = 1'b0;
        #1;
        chk("sat_hit_cnt", bus.hit_cnt, sat(n_hit));
        chk("sat_miss_cnt", bus.miss_cnt, sat(n_miss));
        // Flush arriving while waiting for the fill.
        @(negedge clk);
        bus.pc       = 32'h40;
        bus.pc_valid = 1'b1;
        #1;
        chk("fw_stall", bus.stall_pc, 1);
        n_miss++;
        serve_req(32'h40, 0);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        send_rsp(32'h40);
        bus.pc_valid = 1'b0;
        cnt = 0;
        #1;
        while (bus.stall_pc && cnt < 100) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        chk("fw_fill_plus_flush_cycles", cnt, SETS + 1);
        fetch(32'h1014, 1'b1, 0);
        fetch(32'h40, 1'b1, 0);
        // Flush in IDLE wins over a same-cycle hit.
        @(negedge clk);
        bus.pc       = 32'h44;
        bus.pc_valid = 1'b1;
        bus.flush    = 1'b1;
        #1;
        chk("fi_stall", bus.stall_pc, 1);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.pc_valid = 1'b0;
        cnt = 0;
        #1;
        while (bus.stall_pc && cnt < 100) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        chk("fi_flush_cycles", cnt, SETS);
        fetch(32'h44, 1'b1, 0);
        // Reset in WAIT, then a stale response.
        @(negedge clk);
        bus.pc       = 32'h80;
        bus.pc_valid = 1'b1;
        #1;
        chk("rm_stall", bus.stall_pc, 1);
        serve_req(32'h80, 0);
        rst          = 1'b1;
        bus.pc_valid = 1'b0;
        #1;
        chk("rm_req_valid", bus.mem_req_valid, 0);
        chk("rm_stall_rst", bus.stall_pc, 0);
        chk("rm_hit_cnt", bus.hit_cnt, 0);
        chk("rm_miss_cnt", bus.miss_cnt, 0);
        n_hit  = 0;
        n_miss = 0;
        @(negedge clk);
        rst = 1'b0;
        send_rsp(32'h80);
        #1;
        chk("rm_idle_after_rsp", bus.stall_pc, 0);
        chk("rm_no_req", bus.mem_req_valid, 0);
        chk("rm_miss_after", bus.miss_cnt, 0);
        fetch(32'h80, 1'b1, 0);
        fetch(32'h104, 1'b1, 0);
        fetch(32'h108, 1'b0, 0);
        @(negedge clk);
        bus.pc_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("final_hit_cnt", bus.hit_cnt, sat(n_hit));
        chk("final_miss_cnt", bus.miss_cnt, sat(n_miss));
        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i_cache_set_assoc.md
I_CACHE_SET_ASSOC -- requirements
Module: i_cache_set_assoc

Interface
REQ-001 SHALL have parameter WAYS, default 4, associativity; power of two, 2..16.
REQ-002 SHALL have parameter SETS, default 16, sets; power of two, >=2.
REQ-003 SHALL have parameter CL_WORDS, default 4, 32-bit words per line; power of two, >=2.
REQ-004 SHALL have parameter CNT_W, default 32, width of the hit/miss counters.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-008 SHALL have port pc  input  32  fetch address, word aligned.
REQ-009 SHALL have port pc_valid  input  1  a fetch is requested this cycle.
REQ-010 SHALL have port flush  input  1  fence.i pulse; invalidates every line.
REQ-011 SHALL have port instr  output  32  registered instruction to the core.
REQ-012 SHALL have port instr_valid  output  1  instr is valid this cycle.
REQ-013 SHALL have port stall_pc  output  1  the core must hold pc.
REQ-014 SHALL have port mem_req_valid  output  1  line fill request.
REQ-015 SHALL have port mem_req_addr  output  32  line-aligned fill address (offset bits zero).
REQ-016 SHALL have port mem_req_ready  input  1  memory accepts the request.
REQ-017 SHALL have port mem_rsp_valid  input  1  fill data valid; single-cycle pulse.
REQ-018 SHALL have port mem_rsp_data  input  CL_WORDS*32  fill line; word 0 in the LSBs.
REQ-019 SHALL have port hit_cnt  output  CNT_W  saturating count of hits.
REQ-020 SHALL have port miss_cnt  output  CNT_W  saturating count of misses.

Function
REQ-021 SHALL split pc into three fields:
- word offset: pc[$clog2(CL_WORDS)+1:2]
- index: next $clog2(SETS) bits
- tag: remaining upper bits.
REQ-022 SHALL declare a hit when pc_valid is high and any valid way of the indexed set has a matching tag; only that way is used.
REQ-023 SHALL, in IDLE, return a hit with 1-cycle latency: pc at cycle N gives instr and instr_valid=1 at N+1; stall_pc=0.
REQ-024 SHALL, in IDLE, on a miss:
- drive stall_pc=1 combinationally in that cycle
- latch the line address and the chosen victim way
- go to REQ.
REQ-025 SHALL have FSM states IDLE, REQ, WAIT, FILL and FLUSH; stall_pc=1 and instr_valid=0 in every state other than IDLE.
REQ-026 SHALL, in REQ, hold mem_req_valid=1 with a stable mem_req_addr until mem_req_ready=1, then go to WAIT.
REQ-027 SHALL, in WAIT, go to FILL on mem_rsp_valid; SHALL ignore mem_rsp_valid in all other states.
REQ-028 SHALL, in FILL, write the data, tag and valid=1 into the victim way, then go to IDLE; the re-presented pc then hits.
REQ-029 SHALL choose the victim as the lowest-index invalid way in the set, otherwise the way given by that set's tree-PLRU.
REQ-030 SHALL keep WAYS-1 PLRU bits per set, updated to point away from the accessed way on every hit and every fill.
REQ-031 SHALL enter FLUSH when flush=1 in IDLE, with priority over a same-cycle lookup; that lookup is neither served nor counted.
REQ-032 SHALL, in FLUSH, clear the valid and PLRU bits of one set per cycle (set counter 0..SETS-1), then go to IDLE; FLUSH lasts exactly SETS cycles.
REQ-033 SHALL remember a flush that arrives in REQ, WAIT or FILL and start FLUSH right after FILL completes; a flush arriving during FLUSH is ignored.
REQ-034 SHALL increment hit_cnt once per IDLE hit and miss_cnt once per miss (IDLE to REQ); both saturate at all-ones.

Reset
REQ-035 SHALL, while rst=1, force:
- state IDLE
- all valid and PLRU bits 0
- flush-pending flag 0
- instr, instr_valid, mem_req_valid, mem_req_addr, hit_cnt, miss_cnt = 0.
REQ-036 SHALL NOT reset the data and tag arrays.
REQ-037 SHALL, if rst is asserted mid-fill, drop the fill without writing it, and SHALL ignore any mem_rsp_valid that arrives after reset.

Verification
REQ-038 SHALL be verified cold miss: pc=0x100 after reset -> stall_pc=1; mem_req_addr=0x100 until ready; after a response carrying 0xAAAA0000..3, pc=0x104 hits with instr=0xAAAA0001 one cycle later; miss_cnt=1, hit_cnt=1.
REQ-039 SHALL be verified on set conflict: with WAYS=4, fill 5 lines of the same index, touching way 0 between fills -> 5th fill evicts the PLRU way, not way 0; way 0 still hits.
REQ-040 SHALL be verified on backpressure: mem_req_ready low for 7 cycles -> mem_req_valid and mem_req_addr stay stable; exactly one request is accepted.
REQ-041 SHALL be verified on flush: pulse flush while in WAIT -> fill completes, then FLUSH for SETS cycles; afterwards a previously hit pc misses.
REQ-042 SHALL be verified on counter saturation: CNT_W=4 with 20 hits -> hit_cnt=15.
REQ-043 SHALL be verified on reset mid-fill: rst pulsed in WAIT, then mem_rsp_valid -> state IDLE; the address misses again.
